// File: rtl/mul_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_issue_ctrl_if                                            |
// | Description : Handshake bundle between the EX-stage multiply issue         |
// |               controller (master) and the shared iterative Multiplier      |
// |               (slave).                                                     |
// |   master drives : mul_valid, mul_flush, mul_word, mul_signed[1:0],         |
// |                   mul_multiplicand, mul_multiplier                         |
// |   slave drives  : mul_ready, mul_out_valid, mul_result_hi, mul_result_lo   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mul_issue_ctrl_if #(
  parameter int XLEN = 64
);
  logic            mul_valid;
  logic            mul_ready;
  logic            mul_flush;
  logic            mul_word;
  logic [1:0]      mul_signed;        // [1] rs1 signed, [0] rs2 signed
  logic [XLEN-1:0] mul_multiplicand;
  logic [XLEN-1:0] mul_multiplier;
  logic            mul_out_valid;
  logic [XLEN-1:0] mul_result_hi;
  logic [XLEN-1:0] mul_result_lo;

  modport master (
    output mul_valid, mul_flush, mul_word, mul_signed,
           mul_multiplicand, mul_multiplier,
    input  mul_ready, mul_out_valid, mul_result_hi, mul_result_lo
  );

  modport slave (
    input  mul_valid, mul_flush, mul_word, mul_signed,
           mul_multiplicand, mul_multiplier,
    output mul_ready, mul_out_valid, mul_result_hi, mul_result_lo
  );
endinterface
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_issue_ctrl                                               |
// | Description : Sequences the shared iterative 64-bit Multiplier for the EX  |
// |               stage. Accepts one M-extension multiply at a time, drives    |
// |               the Multiplier handshake with signedness/word controls,      |
// |               handles flush and a watchdog timeout, then selects and holds |
// |               the (sign-extended) result for writeback.                    |
// | Ports       :                                                              |
// |   mul_clk, resetn          clock, synchronous active-low reset             |
// |   req_valid/req_ready      request handshake from EX                       |
// |   req_op, req_word         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; MULW      |
// |   req_rs1, req_rs2, req_rd operands and destination register              |
// |   flush                    pipeline flush                                  |
// |   mul_bus                  Multiplier bundle (master side)                 |
// |   wb_valid/wb_ready        writeback handshake                             |
// |   wb_data, wb_rd           writeback result and destination                |
// |   timeout_err              one-cycle pulse on watchdog abort               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_issue_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 0,   // 0 disables the watchdog
  parameter int CNT_W   = 8    // 2**CNT_W must exceed TIMEOUT
) (
  input  logic             mul_clk,
  input  logic             resetn,
  // request from EX
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  // Multiplier
  mul_issue_ctrl_if.master mul_bus,
  // writeback
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd,
  output logic             timeout_err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [1:0] c_op_mul    = 2'b00;
  localparam logic [1:0] c_op_mulh   = 2'b01;
  localparam logic [1:0] c_op_mulhsu = 2'b10;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic             c_wdog_en = (TIMEOUT != 0);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;

  logic [XLEN-1:0]  r_rs1;
  logic [XLEN-1:0]  r_rs2;
  logic [4:0]       r_rd;
  logic [1:0]       r_op;
  logic             r_word;
  logic [XLEN-1:0]  r_wb_data;
  logic [4:0]       r_wb_rd;
  logic [CNT_W-1:0] r_cnt;

  logic             w_req_ready;
  logic             w_mul_valid;
  logic             w_mul_flush;
  logic             w_wb_valid;
  logic             w_timeout;
  logic             w_accept;
  logic             w_mul_hs;
  logic             w_capture;
  logic [1:0]       w_signed;
  logic [XLEN-1:0]  w_result;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge mul_clk) begin : p_state_reg
    if (!resetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output / handshake decode
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_out
    w_req_ready = 1'b0;
    w_mul_valid = 1'b0;
    w_wb_valid  = 1'b0;
    w_timeout   = 1'b0;
    w_mul_flush = 1'b0;
    if (!flush) begin
      w_req_ready = (r_state == c_st_idle) ||
                    ((r_state == c_st_done) && wb_ready);
      w_mul_valid = (r_state == c_st_req);
      w_wb_valid  = (r_state == c_st_done);
      // A result arriving on the same cycle as the timeout takes precedence.
      w_timeout   = c_wdog_en && (r_state == c_st_wait) &&
                    !mul_bus.mul_out_valid && (r_cnt == c_timeout);
    end
    // The watchdog abort reuses the Multiplier flush to cancel the operation.
    w_mul_flush = (flush && ((r_state == c_st_req) || (r_state == c_st_wait))) ||
                  w_timeout;
  end

  assign w_accept  = req_valid && w_req_ready;
  assign w_mul_hs  = w_mul_valid && mul_bus.mul_ready;
  assign w_capture = (r_state == c_st_wait) && mul_bus.mul_out_valid && !flush;

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_next
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) w_next_state = c_st_req;
      end
      c_st_req: begin
        if (flush)         w_next_state = c_st_idle;
        else if (w_mul_hs) w_next_state = c_st_wait;
      end
      c_st_wait: begin
        if (flush)                      w_next_state = c_st_idle;
        else if (mul_bus.mul_out_valid) w_next_state = c_st_done;
        else if (w_timeout)             w_next_state = c_st_idle;
      end
      c_st_done: begin
        if (flush)         w_next_state = c_st_idle;
        else if (wb_ready) w_next_state = w_accept ? c_st_req : c_st_idle;
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand signedness and result selection from the registered op
  // --------------------------------------------------------------------------
  always_comb begin : p_signed
    w_signed = 2'b00;
    if (r_word) begin
      w_signed = 2'b11;
    end else begin
      case (r_op)
        c_op_mul, c_op_mulh: w_signed = 2'b11;
        c_op_mulhsu:         w_signed = 2'b10;
        default:             w_signed = 2'b00;
      endcase
    end
  end

  always_comb begin : p_result
    w_result = mul_bus.mul_result_hi;
    if (r_word) begin
      w_result = {{(XLEN-32){mul_bus.mul_result_lo[31]}}, mul_bus.mul_result_lo[31:0]};
    end else if (r_op == c_op_mul) begin
      w_result = mul_bus.mul_result_lo;
    end
  end

  // --------------------------------------------------------------------------
  // Request registers, result hold registers and watchdog counter
  // --------------------------------------------------------------------------
  always_ff @(posedge mul_clk) begin : p_datapath
    if (!resetn) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_op      <= '0;
      r_word    <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_rs1  <= req_rs1;
        r_rs2  <= req_rs2;
        r_rd   <= req_rd;
        r_op   <= req_op;
        r_word <= req_word;
      end
      // The writeback copy of rd is separate so a back-to-back accept in
      // DONE cannot disturb the destination of the result being retired.
      if (w_capture) begin
        r_wb_data <= w_result;
        r_wb_rd   <= r_rd;
      end
      if (w_mul_hs && !flush) begin
        r_cnt <= '0;
      end else if (c_wdog_en && (r_state == c_st_wait) &&
                   !mul_bus.mul_out_valid && (r_cnt != c_timeout)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all forced low while reset is asserted
  // --------------------------------------------------------------------------
  assign req_ready                = resetn && w_req_ready;
  assign mul_bus.mul_valid        = resetn && w_mul_valid;
  assign mul_bus.mul_flush        = resetn && w_mul_flush;
  assign mul_bus.mul_word         = resetn && r_word;
  assign mul_bus.mul_signed       = resetn ? w_signed : 2'b00;
  assign mul_bus.mul_multiplicand = resetn ? r_rs1 : '0;
  assign mul_bus.mul_multiplier   = resetn ? r_rs2 : '0;
  assign wb_valid                 = resetn && w_wb_valid;
  assign wb_data                  = resetn ? r_wb_data : '0;
  assign wb_rd                    = resetn ? r_wb_rd : 5'd0;
  assign timeout_err              = resetn && w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_issue_ctrl                                            |
// | Description : Self-checking bench for mul_issue_ctrl with a Multiplier     |
// |               stub and a writeback scoreboard.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_issue_ctrl;
  localparam int XLEN    = 64;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_word = 1'b0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        timeout_err;

  exp_t scb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Multiplier stub controls and state
  logic        stub_ready = 1'b1;
  logic        stub_en = 1'b1;
  int          stub_lat = 2;
  int          st_cnt = 0;
  logic        st_ov = 1'b0;
  logic [63:0] st_a = '0, st_b = '0, st_hi = '0, st_lo = '0;
  logic [1:0]  st_sg = 2'b00;

  mul_issue_ctrl_if #(.XLEN(XLEN)) bus ();

  mul_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .mul_clk     (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_word    (req_word),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd      (req_rd),
    .flush       (flush),
    .mul_bus     (bus.master),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // 128-bit product with per-operand sign extension
  function automatic logic [127:0] prod128(input logic sa, input logic sb,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb;
    ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  // Architectural result of an M-extension multiply
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    if (w) begin
      p = prod128(1'b1, 1'b1, a, b);
      return {{32{p[31]}}, p[31:0]};
    end
    case (op)
      2'b00:   begin p = prod128(1'b1, 1'b1, a, b); return p[63:0];   end
      2'b01:   begin p = prod128(1'b1, 1'b1, a, b); return p[127:64]; end
      2'b10:   begin p = prod128(1'b1, 1'b0, a, b); return p[127:64]; end
      default: begin p = prod128(1'b0, 1'b0, a, b); return p[127:64]; end
    endcase
  endfunction

  // Multiplier stub: uses the controller's signedness to form the product,
  // answers stub_lat cycles after the handshake, ignores mul_flush.
  assign bus.mul_ready     = stub_ready;
  assign bus.mul_out_valid = st_ov;
  assign bus.mul_result_hi = st_hi;
  assign bus.mul_result_lo = st_lo;

  always @(posedge clk) begin
    st_ov <= 1'b0;
    if (bus.mul_valid && bus.mul_ready) begin
      st_cnt <= stub_lat;
      st_a   <= bus.mul_multiplicand;
      st_b   <= bus.mul_multiplier;
      st_sg  <= bus.mul_signed;
    end else if (st_cnt == 1) begin
      st_cnt <= 0;
      if (stub_en) begin
        st_ov          <= 1'b1;
        {st_hi, st_lo} <= prod128(st_sg[1], st_sg[0], st_a, st_b);
      end
    end else if (st_cnt > 1) begin
      st_cnt <= st_cnt - 1;
    end
  end

  // Writeback scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (resetn && wb_valid && wb_ready) begin
      n_checks++;
      if (scb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got data %h rd %0d, required no writeback", wb_data, wb_rd);
      end else begin
        e = scb.pop_front();
        if (wb_data !== e.data || wb_rd !== e.rd) begin
          n_fail++;
          $display("FAIL wb_result: got data %h rd %0d, required data %h rd %0d",
                   wb_data, wb_rd, e.data, e.rd);
        end
      end
    end
  end

  // Present a request until accepted and record its expected writeback.
  task automatic do_req(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp_data);
    int k;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_word = w;
    req_rs1 = a; req_rs2 = b; req_rd = rd;
    k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_accept: req_ready=%b, required 1", req_ready);
    end
    scb.push_back('{exp_data, rd});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; req_valid = 1'b1; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, bus.mul_valid, bus.mul_flush, wb_valid, timeout_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {req_ready, bus.mul_valid, bus.mul_flush, wb_valid, timeout_err});
    end
    n_checks++;
    if ({wb_data, wb_rd, bus.mul_signed, bus.mul_word} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got wb_data %h wb_rd %0d signed %b, required 0",
               wb_data, wb_rd, bus.mul_signed);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || bus.mul_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got req_ready %b mul_valid %b, required 1 0",
               req_ready, bus.mul_valid);
    end
  endtask

  task automatic test_mulhu;
    int k;
    stub_ready = 1'b0;
    do_req(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'h1);
    // Operands and controls must hold while the Multiplier stalls.
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mul_valid, bus.mul_word, bus.mul_signed, bus.mul_multiplicand, bus.mul_multiplier}
          !== {1'b1, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2}) begin
        n_fail++;
        $display("FAIL mulhu_req: got valid %b word %b signed %b a %h b %h, required 1 0 00 ffffffffffffffff 2",
                 bus.mul_valid, bus.mul_word, bus.mul_signed, bus.mul_multiplicand, bus.mul_multiplier);
      end
    end
    @(posedge clk); #1;
    stub_ready = 1'b1;
    k = 0;
    while (scb.size() != 0 && k < 40) begin @(posedge clk); k++; end
    n_checks++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_mulhu: %0d outstanding, required 0", scb.size());
    end
  endtask

  task automatic test_mulh_mulhsu;
    int k;
    do_req(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    n_checks++;
    if (bus.mul_signed !== 2'b11 || bus.mul_word !== 1'b0) begin
      n_fail++;
      $display("FAIL mulh_signed: got %b word %b, required 11 0", bus.mul_signed, bus.mul_word);
    end
    do_req(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    n_checks++;
    if (bus.mul_signed !== 2'b10) begin
      n_fail++;
      $display("FAIL mulhsu_signed: got %b, required 10", bus.mul_signed);
    end
    k = 0;
    while (scb.size() != 0 && k < 40) begin @(posedge clk); k++; end
    n_checks++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_mulh: %0d outstanding, required 0", scb.size());
    end
  endtask

  task automatic test_mulw_mul;
    int k;
    // req_op is don't-care for MULW; drive the MULHU encoding to prove it.
    do_req(2'b11, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    n_checks++;
    if (bus.mul_word !== 1'b1 || bus.mul_signed !== 2'b11) begin
      n_fail++;
      $display("FAIL mulw_ctrl: got word %b signed %b, required 1 11", bus.mul_word, bus.mul_signed);
    end
    do_req(2'b00, 1'b0, 64'd3, 64'd5, 5'd9, 64'hF);
    @(negedge clk);
    n_checks++;
    if (bus.mul_word !== 1'b0 || bus.mul_signed !== 2'b11) begin
      n_fail++;
      $display("FAIL mul_ctrl: got word %b signed %b, required 0 11", bus.mul_word, bus.mul_signed);
    end
    k = 0;
    while (scb.size() != 0 && k < 40) begin @(posedge clk); k++; end
    n_checks++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_mulw: %0d outstanding, required 0", scb.size());
    end
  endtask

  task automatic test_back_to_back;
    int k;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    do_req(2'b00, 1'b0, 64'd7, 64'd6, 5'd9, 64'h2A);
    k = 0;
    @(negedge clk);
    while (wb_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_data !== 64'h2A || wb_rd !== 5'd9) begin
        n_fail++;
        $display("FAIL bp_hold: got valid %b data %h rd %0d, required 1 2a 9", wb_valid, wb_data, wb_rd);
      end
    end
    @(posedge clk); #1;
    wb_ready = 1'b1; req_valid = 1'b1; req_op = 2'b11; req_word = 1'b0;
    req_rs1 = 64'hFFFF_FFFF_FFFF_FFFF; req_rs2 = 64'hFFFF_FFFF_FFFF_FFFF; req_rd = 5'd11;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b, required 1", req_ready);
    end
    scb.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 5'd11});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mul_valid !== 1'b1 || bus.mul_signed !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_issue: got mul_valid %b signed %b, required 1 00", bus.mul_valid, bus.mul_signed);
    end
    k = 0;
    while (scb.size() != 0 && k < 40) begin @(posedge clk); k++; end
    n_checks++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_b2b: %0d outstanding, required 0", scb.size());
    end
  endtask

  task automatic test_random;
    int k;
    logic [1:0]  op;
    logic        w;
    logic [63:0] a, b;
    logic [4:0]  rd;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      rd = 5'($urandom_range(1, 31));
      stub_lat = $urandom_range(1, 3);
      do_req(op, w, a, b, rd, ref_res(op, w, a, b));
      k = 0;
      while (scb.size() != 0 && k < 40) begin @(posedge clk); k++; end
      n_checks++;
      if (scb.size() != 0) begin
        n_fail++;
        $display("FAIL drain_random: %0d outstanding, required 0", scb.size());
      end
    end
    stub_lat = 2;
  endtask

  task automatic test_flush;
    logic bad;
    stub_lat = 8;
    do_req(2'b00, 1'b0, 64'd11, 64'd13, 5'd10, 64'd143);
    void'(scb.pop_back());
    @(negedge clk);                 // REQ, handshake at the next edge
    @(posedge clk); #1;             // now in WAIT
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mul_flush !== 1'b1 || req_ready !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wait: got mul_flush %b req_ready %b wb_valid %b, required 1 0 0",
               bus.mul_flush, req_ready, wb_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mul_flush !== 1'b0 || bus.mul_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_next: got mul_flush %b mul_valid %b req_ready %b, required 0 0 1",
               bus.mul_flush, bus.mul_valid, req_ready);
    end
    // The stub still answers later; that result must be dropped.
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL flush_late_result: got wb_valid 1, required 0");
    end
    stub_lat = 2;
    // Flush coinciding with a request in IDLE blocks acceptance.
    @(posedge clk); #1;
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_word = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_ready: got %b, required 0", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mul_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_noaccept: got mul_valid %b req_ready %b, required 0 1",
               bus.mul_valid, req_ready);
    end
  endtask

  task automatic test_watchdog;
    stub_en = 1'b0;
    do_req(2'b01, 1'b0, 64'd1, 64'd1, 5'd12, 64'd0);
    void'(scb.pop_back());
    @(negedge clk);                 // REQ
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);               // WAIT cycle i (IDLE at i=6)
      n_checks++;
      if (timeout_err !== (i == 5) || bus.mul_flush !== (i == 5) || wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL watchdog_c%0d: got timeout_err %b mul_flush %b wb_valid %b, required %b %b 0",
                 i, timeout_err, bus.mul_flush, wb_valid, (i == 5), (i == 5));
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    do_req(2'b10, 1'b0, 64'd5, 64'd9, 5'd13, 64'd0);
    void'(scb.pop_back());
    @(negedge clk);                 // REQ
    @(negedge clk);                 // WAIT
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, bus.mul_valid, bus.mul_flush, bus.mul_word, bus.mul_signed, wb_valid, timeout_err} !== 8'b0 ||
        {bus.mul_multiplicand, bus.mul_multiplier, wb_data, wb_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_wait_outputs: got ready %b mvalid %b mflush %b signed %b a %h b %h, required all 0",
               req_ready, bus.mul_valid, bus.mul_flush, bus.mul_signed,
               bus.mul_multiplicand, bus.mul_multiplier);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    stub_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || bus.mul_valid !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_wait_idle: got req_ready %b mul_valid %b wb_valid %b wb_data %h, required 1 0 0 0",
               req_ready, bus.mul_valid, wb_valid, wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_mulhu();
    test_mulh_mulhsu();
    test_mulw_mul();
    test_back_to_back();
    test_random();
    test_flush();
    test_watchdog();
    test_reset_mid_wait();
    repeat (5) @(posedge clk);
    n_checks++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: %0d outstanding, required 0", scb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequences the shared iterative 64-bit Multiplier for the EX stage of the RV64 core.
- Accepts one decoded M-extension multiply (MUL/MULH/MULHSU/MULHU/MULW), drives the Multiplier valid/ready handshake, signedness and word controls, and handles flush and timeout.
- Selects and sign-extends the result, then holds it for writeback under valid/ready backpressure.

Parameters:
- XLEN, 64, operand/result width
- TIMEOUT, 0, max cycles in WAIT before forced abort; 0 disables the watchdog
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  EX presents a multiply
- req_ready  out  1  controller accepts the request
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_word  in  1  MULW (32-bit op; req_op ignored)
- req_rs1  in  XLEN  multiplicand
- req_rs2  in  XLEN  multiplier
- req_rd  in  5  destination register
- flush  in  1  pipeline flush
- mul_valid  out  1  to Multiplier io_i_mul_valid
- mul_ready  in  1  from io_o_mul_ready
- mul_flush  out  1  to io_i_flush
- mul_word  out  1  to io_i_mulw
- mul_signed  out  2  to io_i_mul_signed: [1] rs1 signed, [0] rs2 signed
- mul_multiplicand  out  XLEN  to io_i_multiplicand
- mul_multiplier  out  XLEN  to io_i_multiplier
- mul_out_valid  in  1  from io_o_out_valid
- mul_result_hi  in  XLEN  from io_o_result_hi
- mul_result_lo  in  XLEN  from io_o_result_lo
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  XLEN  result
- wb_rd  out  5  destination register
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (resetn=0 at posedge): state=IDLE, watchdog count=0, all registers 0. While resetn=0, every output is 0, including req_ready.
- Request acceptance: req_ready = !flush && (IDLE || (DONE && wb_ready)).
  - On acceptance, register rs1, rs2, rd, op and word.
  - Go to REQ next cycle; DONE->REQ back-to-back is allowed.
- Signedness, derived from the registered op: MUL {1,1}; MULH {1,1}; MULHSU {1,0}; MULHU {0,0}; word=1 gives {1,1} with mul_word=1.
- REQ state:
  - mul_valid = !flush. Operands and controls stay stable until mul_valid && mul_ready.
  - On that handshake go to WAIT and clear the watchdog count.
- WAIT state:
  - mul_out_valid captures wb_data and goes to DONE.
  - Result select: word gives sext(lo[31:0]); MUL gives lo; MULH/MULHSU/MULHU give hi.
  - mul_out_valid in any other state is ignored.
- Latency: accept at cycle 0, mul_valid at cycle 1. wb_valid is asserted the cycle after mul_out_valid.
- DONE state:
  - wb_valid = !flush. wb_data and wb_rd are held stable while wb_valid && !wb_ready.
  - wb_valid && wb_ready returns to IDLE, or to REQ if a new request is accepted in the same cycle.
- Flush (any cycle):
  - mul_flush = flush && state in {REQ, WAIT}.
  - Next state is IDLE. No handshake completes in the flush cycle.
  - A mul_out_valid coinciding with flush is discarded.
  - In IDLE, flush only blocks acceptance.
- Watchdog (TIMEOUT>0):
  - Count increments each WAIT cycle without mul_out_valid.
  - When the count reaches TIMEOUT: pulse timeout_err and mul_flush for one cycle, go to IDLE, no writeback.
  - If mul_out_valid and the timeout coincide, mul_out_valid wins.
- Only one operation is in flight; there are no queueing or reordering states.

Test Plan:
- MULHU: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> mul_signed=00; wb_data=0x1, rd echoed.
- MULH: rs1=-1, rs2=2 -> mul_signed=11; wb_data=0xFFFF_FFFF_FFFF_FFFF. MULHSU with the same operands -> mul_signed=10, same wb_data.
- MULW: rs1=0x7FFF_FFFF, rs2=2 -> mul_word=1; wb_data=0xFFFF_FFFF_FFFF_FFFE. MUL: 3*5 -> 0xF.
- Backpressure and back-to-back:
  - Hold wb_ready=0 for 5 cycles -> wb_valid and wb_data stable.
  - Then wb_ready=1 with a new req_valid -> req_ready=1 that cycle; mul_valid=1 the next cycle.
- Flush:
  - Flush in WAIT -> mul_flush=1 for exactly that cycle, IDLE next; a later mul_out_valid is ignored.
  - Flush coinciding with req_valid in IDLE -> not accepted.
- Watchdog: TIMEOUT=4 with Multiplier stub never asserting out_valid -> timeout_err and mul_flush pulse after 4 WAIT cycles, wb_valid never asserted. resetn=0 mid-WAIT -> IDLE, all outputs 0.
